// File: rtl/inst_fetch_buf_pkg.sv
// ============================================================================
//  Module   : inst_fetch_buf_pkg
//  Brief    : Shared widths, instruction constants and helpers for the
//             instruction fetch buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_buf_pkg;

  // Default instruction address and instruction widths
  localparam int c_addr_w = 32;
  localparam int c_inst_w = 32;

  // Canonical NOP (addi x0, x0, 0) and an all-zero word
  localparam logic [31:0] c_nop_inst  = 32'h0000_0013;
  localparam logic [31:0] c_zero_word = 32'h0000_0000;

  // Sequential fetch stride in bytes
  localparam int c_pc_step = 4;

  // Pointer width for a power-of-two FIFO depth
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifb_fifo.sv
// ============================================================================
//  Module   : ifb_fifo
//  Brief    : Power-of-two FIFO holding {pc, inst} entries for the fetch
//             buffer. Supports push/pop, a single-cycle flush, and exposes
//             full/empty/count. Head entry is shown combinationally.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ifb_fifo
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [ptr_width(DEPTH):0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is only legal when a pop frees the slot
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush behaves like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !rst) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_buf.sv
// ============================================================================
//  Module   : inst_fetch_buf
//  Brief    : Instruction prefetch buffer. Issues sequential ROM requests
//             (one in flight, credit-limited by FIFO space), queues returned
//             {pc, inst} pairs and presents the head to decode. A redirect
//             flushes the queue, kills the in-flight response and restarts
//             fetch at the word-aligned target.
//  Config   : define IFB_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               ADDR_W   = c_addr_w,
  parameter int               INST_W   = c_inst_w,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef IFB_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_pc;

  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_unused_fifo_full;
  logic [1:0]        w_unused_redirect_lsb;
  logic [PTR_W:0]    w_fifo_count;
  logic [PTR_W+1:0]  w_occ;
  logic [ENT_W-1:0]  w_head;

  // Entries already queued plus the one that may still be returning
  assign w_occ   = {1'b0, w_fifo_count} + {{(PTR_W+1){1'b0}}, r_req_valid};
  assign w_issue = !rst && !redirect_en && (w_occ < (PTR_W+2)'(DEPTH));

  assign rom_ce   = w_issue;
  assign rom_addr = rst ? RESET_PC : r_fetch_pc;

  // A response arriving during a redirect belongs to the old stream
  assign w_push = r_req_valid && !redirect_en;

  assign id_valid = !w_fifo_empty && !rst;
  assign w_pop    = id_valid && id_ready && !redirect_en;
  assign id_pc    = id_valid ? w_head[ENT_W-1:INST_W] : '0;
  assign id_inst  = id_valid ? w_head[INST_W-1:0]     : '0;

  // Target is forced to a word boundary, so the low bits are ignored
  assign w_unused_redirect_lsb = redirect_pc[1:0];

  ifb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_en),
    .wdata ({r_req_pc, rom_inst}),
    .rdata (w_head),
    .full  (w_unused_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Fetch PC and in-flight request tracking; reset beats redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (redirect_en) begin
      r_fetch_pc  <= {redirect_pc[ADDR_W-1:2], 2'b00};
      r_req_valid <= 1'b0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_W'(c_pc_step);
      end
    end
  end

`ifdef IFB_PERF_EN
  // Count delivered instructions and decode-starved cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_pop)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
